// File: rtl/debug_slave_cmd_sync.sv
// System-clock side of the CPU JTAG debug slave. TCK-domain update strobes
// are synchronised and edge-detected here. Each update-DR becomes a queued
// {ir, sr} command, which is handed to the OCI logic over a valid/ready
// handshake. Every consumed command produces a one-hot action pulse.
module debug_slave_cmd_sync #(
  parameter int SR_W        = 38,
  parameter int IR_W        = 2,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [IR_W-1:0]              ir_in,
  input  logic [SR_W-1:0]              sr,
  input  logic                         vs_uir,
  input  logic                         vs_udr,
  input  logic                         cmd_ready,
  input  logic                         ovf_clr,
  output logic                         cmd_valid,
  output logic [IR_W-1:0]              cmd_ir,
  output logic [SR_W-1:0]              jdo,
  output logic [2**IR_W-1:0]           take_action,
  output logic [2**IR_W-1:0]           take_no_action,
  output logic [$clog2(DEPTH+1)-1:0]   fill,
  output logic                         overflow
);

  localparam int NCH    = 2**IR_W;
  localparam int FILL_W = $clog2(DEPTH+1);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int ENT_W  = IR_W + SR_W;
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(DEPTH);

  logic [SYNC_STAGES-1:0] uir_sync;
  logic [SYNC_STAGES-1:0] udr_sync;
  logic [SYNC_STAGES-1:0] samp_ok;
  logic                   uir_hist;
  logic                   udr_hist;
  logic                   uir_armed;
  logic                   udr_armed;
  logic                   uir_last;
  logic                   udr_last;
  logic                   uir_ev;
  logic                   udr_ev;

  logic [IR_W-1:0]        ir_q;
  logic [IR_W-1:0]        push_ir;

  logic [ENT_W-1:0]       mem [DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [ENT_W-1:0]       head;
  logic [IR_W-1:0]        head_ir;
  logic                   full;
  logic                   push;
  logic                   pop;
  logic                   wr_en;
  logic                   drop;

  assign uir_last = uir_sync[SYNC_STAGES-1];
  assign udr_last = udr_sync[SYNC_STAGES-1];

  // A strobe only counts as rising once its last stage has held a real low
  // sample since reset. A strobe that is still high when reset is released
  // therefore produces no event until it goes low and rises again.
  assign uir_ev = uir_last & ~uir_hist & uir_armed;
  assign udr_ev = udr_last & ~udr_hist & udr_armed;

  // Synchroniser chains, edge history and post-reset arming
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      uir_sync  <= '0;
      udr_sync  <= '0;
      samp_ok   <= '0;
      uir_hist  <= 1'b0;
      udr_hist  <= 1'b0;
      uir_armed <= 1'b0;
      udr_armed <= 1'b0;
    end else begin
      uir_sync  <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
      udr_sync  <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
      samp_ok   <= {samp_ok[SYNC_STAGES-2:0], 1'b1};
      uir_hist  <= uir_last;
      udr_hist  <= udr_last;
      uir_armed <= uir_armed | (samp_ok[SYNC_STAGES-1] & ~uir_last);
      udr_armed <= udr_armed | (samp_ok[SYNC_STAGES-1] & ~udr_last);
    end
  end

  // Instruction register capture on update-IR
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ir_q <= '0;
    end else if (uir_ev) begin
      ir_q <= ir_in;
    end
  end

  // When update-IR and update-DR land together, the new instruction wins.
  assign push_ir = uir_ev ? ir_in : ir_q;

  assign head      = mem[rd_ptr];
  assign head_ir   = head[ENT_W-1:SR_W];
  assign cmd_valid = (fill != '0);
  assign full      = (fill == FILL_FULL);
  assign push      = udr_ev;
  assign pop       = cmd_valid & cmd_ready;
  assign wr_en     = push & (~full | pop);
  assign drop      = push & full & ~pop;

  // The head is only meaningful while valid. Forcing it to zero otherwise
  // keeps the outputs clean after reset without resetting the storage.
  assign cmd_ir = cmd_valid ? head_ir : '0;
  assign jdo    = cmd_valid ? head[SR_W-1:0] : '0;

  // Command storage. When the FIFO is full and a pop coincides with a push,
  // the write lands in the slot that is being vacated.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= {push_ir, sr};
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (wr_en && !pop) begin
        fill <= fill + FILL_W'(1);
      end else if (pop && !wr_en) begin
        fill <= fill - FILL_W'(1);
      end
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps it set
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

  // One-cycle action pulses for the command popped on the previous edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      take_action    <= '0;
      take_no_action <= '0;
    end else begin
      take_action    <= '0;
      take_no_action <= '0;
      if (pop) begin
        if (head[SR_W-1]) begin
          take_action <= NCH'(1) << head_ir;
        end else begin
          take_no_action <= NCH'(1) << head_ir;
        end
      end
    end
  end

endmodule

// File: tb/tb_debug_slave_cmd_sync.sv
// Directed and randomized checks of debug_slave_cmd_sync against a queue model.
module tb_debug_slave_cmd_sync;

  localparam int SR_W        = 38;
  localparam int IR_W        = 2;
  localparam int DEPTH       = 4;
  localparam int SYNC_STAGES = 2;
  localparam int NCH         = 4;
  localparam int FILL_W      = 3;
  localparam int ENT_W       = IR_W + SR_W;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [IR_W-1:0]   ir_in;
  logic [SR_W-1:0]   sr;
  logic              vs_uir;
  logic              vs_udr;
  logic              cmd_ready;
  logic              ovf_clr;
  logic              cmd_valid;
  logic [IR_W-1:0]   cmd_ir;
  logic [SR_W-1:0]   jdo;
  logic [NCH-1:0]    take_action;
  logic [NCH-1:0]    take_no_action;
  logic [FILL_W-1:0] fill;
  logic              overflow;

  always #5 clk = ~clk;

  debug_slave_cmd_sync #(
    .SR_W(SR_W), .IR_W(IR_W), .DEPTH(DEPTH), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk(clk), .reset_n(reset_n), .ir_in(ir_in), .sr(sr),
    .vs_uir(vs_uir), .vs_udr(vs_udr), .cmd_ready(cmd_ready), .ovf_clr(ovf_clr),
    .cmd_valid(cmd_valid), .cmd_ir(cmd_ir), .jdo(jdo),
    .take_action(take_action), .take_no_action(take_no_action),
    .fill(fill), .overflow(overflow)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: ordered list of accepted commands, current IR, sticky flag
  logic [ENT_W-1:0] mq [$];
  logic [IR_W-1:0]  m_irq;
  logic             m_ovf;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [SR_W-1:0] rnd_sr();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[SR_W-1:0];
  endfunction

  task automatic model_push(input logic [IR_W-1:0] ir, input logic [SR_W-1:0] d);
    if (mq.size() < DEPTH) mq.push_back({ir, d});
    else m_ovf = 1'b1;
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_fill"}, 64'(fill), 64'(mq.size()));
    chk({tag, "_valid"}, 64'(cmd_valid), 64'(mq.size() != 0));
    chk({tag, "_ovf"}, 64'(overflow), 64'(m_ovf));
  endtask

  task automatic do_uir(input logic [IR_W-1:0] ir);
    ir_in  = ir;
    vs_uir = 1'b1;
    repeat (3) @(negedge clk);
    vs_uir = 1'b0;
    repeat (4) @(negedge clk);
    m_irq = ir;
  endtask

  task automatic do_udr(input logic [SR_W-1:0] d, input int hold);
    sr     = d;
    vs_udr = 1'b1;
    repeat (hold) @(negedge clk);
    vs_udr = 1'b0;
    repeat (4) @(negedge clk);
    model_push(m_irq, d);
  endtask

  task automatic chk_pulse(input string tag, input logic [ENT_W-1:0] e);
    logic [NCH-1:0] ea;
    logic [NCH-1:0] en;
    ea = '0;
    en = '0;
    if (e[SR_W-1]) ea[e[ENT_W-1:SR_W]] = 1'b1;
    else           en[e[ENT_W-1:SR_W]] = 1'b1;
    chk({tag, "_act"}, 64'(take_action), 64'(ea));
    chk({tag, "_noact"}, 64'(take_no_action), 64'(en));
  endtask

  task automatic pop_chk(input string tag);
    logic [ENT_W-1:0] e;
    e = mq.pop_front();
    chk({tag, "_hvalid"}, 64'(cmd_valid), 64'(1));
    chk({tag, "_ir"}, 64'(cmd_ir), 64'(e[ENT_W-1:SR_W]));
    chk({tag, "_jdo"}, 64'(jdo), 64'(e[SR_W-1:0]));
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    chk_pulse(tag, e);
    chk({tag, "_pfill"}, 64'(fill), 64'(mq.size()));
    @(negedge clk);
    chk({tag, "_act_off"}, 64'(take_action), 64'(0));
    chk({tag, "_noact_off"}, 64'(take_no_action), 64'(0));
  endtask

  task automatic clear_ovf();
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    m_ovf   = 1'b0;
    chk("ovf_clr", 64'(overflow), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [SR_W-1:0]  d;
    logic [ENT_W-1:0] e0;
    int op;

    reset_n = 1'b0; ir_in = '0; sr = '0; vs_uir = 1'b0; vs_udr = 1'b0;
    cmd_ready = 1'b0; ovf_clr = 1'b0;
    m_irq = '0; m_ovf = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 64'(cmd_valid), 64'(0));
    chk("rst_fill", 64'(fill), 64'(0));
    chk("rst_ovf", 64'(overflow), 64'(0));
    chk("rst_act", 64'(take_action), 64'(0));
    chk("rst_noact", 64'(take_no_action), 64'(0));
    chk("rst_ir", 64'(cmd_ir), 64'(0));
    chk("rst_jdo", 64'(jdo), 64'(0));
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    // Basic command with action bit set, plus latency
    do_uir(2'b01);
    sr = 38'h20_0000_1234;
    vs_udr = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("lat_edge1", 64'(cmd_valid), 64'(0));
    @(negedge clk);
    chk("lat_edge2", 64'(cmd_valid), 64'(1));
    chk("lat_ir", 64'(cmd_ir), 64'(1));
    chk("lat_jdo", 64'(jdo), 64'(38'h20_0000_1234));
    @(negedge clk);
    vs_udr = 1'b0;
    repeat (4) @(negedge clk);
    mq.push_back({2'b01, 38'h20_0000_1234});
    check_state("t1");
    pop_chk("t1pop");
    check_state("t1end");

    // No-action command, long strobe must push once
    do_uir(2'b11);
    do_udr(38'h00_dead_beef, 10);
    check_state("t2");
    pop_chk("t2pop");

    // Overflow: five pushes into four slots
    do_uir(2'b10);
    for (int i = 0; i < 4; i++) do_udr(rnd_sr(), 3);
    check_state("t3_full");
    do_udr(rnd_sr(), 3);
    check_state("t3_ovf");
    for (int i = 0; i < 4; i++) pop_chk("t3pop");
    check_state("t3_drained");
    clear_ovf();

    // Full with simultaneous pop and push
    for (int i = 0; i < 4; i++) do_udr(rnd_sr(), 2);
    check_state("t4_full");
    d = rnd_sr();
    sr = d;
    vs_udr = 1'b1;
    @(negedge clk);
    @(negedge clk);
    cmd_ready = 1'b1;
    e0 = mq[0];
    @(negedge clk);
    cmd_ready = 1'b0;
    chk_pulse("t4pp", e0);
    void'(mq.pop_front());
    mq.push_back({m_irq, d});
    chk("t4_fill", 64'(fill), 64'(4));
    chk("t4_ovf", 64'(overflow), 64'(0));
    vs_udr = 1'b0;
    repeat (4) @(negedge clk);
    check_state("t4_after");
    for (int i = 0; i < 4; i++) pop_chk("t4pop");

    // Simultaneous update-IR and update-DR uses the new instruction
    do_uir(2'b11);
    d = rnd_sr();
    ir_in = 2'b10;
    sr = d;
    vs_uir = 1'b1;
    vs_udr = 1'b1;
    repeat (3) @(negedge clk);
    vs_uir = 1'b0;
    vs_udr = 1'b0;
    repeat (4) @(negedge clk);
    m_irq = 2'b10;
    model_push(2'b10, d);
    check_state("t5");
    pop_chk("t5pop");

    // Randomized mix of IR updates, DR updates and pops
    for (int i = 0; i < 30; i++) begin
      op = int'($urandom_range(0, 3));
      if (op == 0) do_uir(IR_W'($urandom_range(0, NCH - 1)));
      else if (op == 3 && mq.size() > 0) pop_chk("rnd_pop");
      else do_udr(rnd_sr(), int'($urandom_range(2, 6)));
    end
    check_state("rnd_end");
    while (mq.size() > 0) pop_chk("rnd_drain");
    clear_ovf();

    // Reset in the middle of operation
    do_uir(2'b01);
    for (int i = 0; i < 3; i++) do_udr(rnd_sr(), 2);
    check_state("t6_q3");
    e0 = mq[0];
    cmd_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_pending", 64'(take_action | take_no_action), 64'(NCH'(1) << e0[ENT_W-1:SR_W]));
    reset_n = 1'b0;
    cmd_ready = 1'b0;
    vs_udr = 1'b1;
    #1;
    chk("t6_valid", 64'(cmd_valid), 64'(0));
    chk("t6_fill", 64'(fill), 64'(0));
    chk("t6_pulses", 64'(take_action | take_no_action), 64'(0));
    chk("t6_ir", 64'(cmd_ir), 64'(0));
    chk("t6_jdo", 64'(jdo), 64'(0));
    mq.delete();
    m_irq = '0;
    m_ovf = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    check_state("t6_held");
    vs_udr = 1'b0;
    repeat (4) @(negedge clk);
    check_state("t6_low");
    do_udr(rnd_sr(), 3);
    check_state("t6_new");
    pop_chk("t6pop");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
